stereo_mixer_seq: RTL and testbench
===================================

// Module: stereo_mixer_seq
// PURPOSE
//  Parametrised, time-multiplexed stereo mixer. Successor to the fixed 3-channel combinational router.
//  Takes NUM_CH signed voices and routes each one to left, right, both or neither.
//  Applies a per-channel attenuation shift, sums one channel per clock and saturates both sums.
//  Presents one registered L/R sample pair with a valid pulse. Sits between the voice generators and the audio output stage.
// PARAMETERS
//  NUM_CH   3   number of voice channels, >=1
//  DATA_W   16  signed sample width, in and out
//  ATT_W    3   attenuation shift width (0..2^ATT_W-1 right shifts)
// PORTS
//  clk_in            in   1                 system clock
//  rst_in            in   1                 reset, asynchronous, active-high
//  sample_valid_in   in   1                 1-cycle strobe: new voice samples present
//  note_data_in      in   NUM_CH*DATA_W     signed samples, ch k at [k*DATA_W +: DATA_W]
//  stereo_in         in   2*NUM_CH          route, ch k at [2k +: 2]: 00 mute, 01 R, 10 L, 11 L+R
//  atten_in          in   NUM_CH*ATT_W      arithmetic right-shift amount per channel
//  clear_flags_in    in   1                 clears sticky flags
//  sample_l_out      out  DATA_W            signed left mix, registered
//  sample_r_out      out  DATA_W            signed right mix, registered
//  sample_valid_out  out  1                 1-cycle pulse: new L/R pair valid
//  busy_out          out  1                 mix in progress, strobes not accepted
//  overrun_out       out  1                 sticky: strobe arrived while busy
//  clip_out          out  1                 sticky: L or R sum saturated
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all outputs 0; accumulators, index and shadow regs 0.
//  Reset mid-mix discards the captured sample. No valid pulse is produced for it.
//  FSM states: IDLE -> ACCUM -> DONE -> IDLE.
//   IDLE:  sample_valid_in=1 -> capture note_data_in, stereo_in, atten_in into shadow regs.
//          Also: acc_l=acc_r=0, idx=0, go ACCUM.
//   ACCUM: v = shadow_data[idx] >>> shadow_att[idx] (signed, floor; -1>>>n = -1).
//          Add v, sign-extended, to acc_l if route bit1=1 and to acc_r if route bit0=1.
//          idx==NUM_CH-1 -> DONE, else idx+1.
//   DONE:  saturate acc_l/acc_r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//          Register the results into sample_l_out/r_out, pulse sample_valid_out, go IDLE.
//  Accumulator width ACC_W = DATA_W + $clog2(NUM_CH+1). No intermediate overflow is possible.
//  Timing, strobe accepted in cycle 0:
//   busy_out is high in cycles 1..NUM_CH+1.
//   Outputs change and sample_valid_out=1 in cycle NUM_CH+2 only.
//   A new strobe is accepted in cycle NUM_CH+2.
//   Max throughput is one sample per NUM_CH+2 cycles.
//  sample_l_out/r_out hold their last value between pulses.
//  Input changes during ACCUM/DONE have no effect, because mixing uses shadow regs only.
//  Strobe while busy_out=1: ignored and overrun_out<=1. The mix in progress is unaffected.
//  clip_out<=1 in DONE if either sum saturated.
//  Sticky flags: clear_flags_in=1 clears both flags next edge. A set in the same cycle wins over the clear.
//  Strobe in the same cycle as sample_valid_out=1 (IDLE): accepted, no overrun.
//  NUM_CH=1: ACCUM lasts exactly one cycle, and the timing formula still holds.
// TESTING
//  1 Reset: assert rst_in mid-ACCUM. Outputs go 0 immediately and no valid pulse follows.
//    After release, the next strobe mixes normally.
//  2 Routing, NUM_CH=3, att=0: data {100,200,300}, route {10,01,11}.
//    Expect L=400, R=500, valid_out in cycle 5 only.
//  3 Saturation: DATA_W=16, 3 ch of 20000 routed 11 -> L=R=32767, clip_out=1.
//    3 ch of -20000 -> L=R=-32768.
//  4 Attenuation: data -1000 att 2 -> -250; data -1 att 3 -> -1.
//    Check odd value: -7 att 1 -> -4.
//  5 Overrun: strobe in cycles 0 and 2 -> one valid pulse (cycle 5), result from cycle-0 data, overrun_out=1.
//    clear_flags_in then clears it.
//  6 Back-to-back: strobes in cycles 0, 5, 10 -> three pulses (cycles 5, 10, 15), no overrun.
//    Also: mute (00) on all channels -> L=R=0.

Source files
------------

// File: rtl/stereo_mixer_seq.sv
// Time-multiplexed stereo mixer: captures NUM_CH voices on a strobe, accumulates one
// voice per clock into left/right sums, then saturates and presents a registered L/R pair.
module stereo_mixer_seq #(
   parameter int NUM_CH = 3,
   parameter int DATA_W = 16,
   parameter int ATT_W  = 3
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       sample_valid_in,
   input  logic [NUM_CH*DATA_W-1:0]   note_data_in,
   input  logic [2*NUM_CH-1:0]        stereo_in,
   input  logic [NUM_CH*ATT_W-1:0]    atten_in,
   input  logic                       clear_flags_in,
   output logic [DATA_W-1:0]          sample_l_out,
   output logic [DATA_W-1:0]          sample_r_out,
   output logic                       sample_valid_out,
   output logic                       busy_out,
   output logic                       overrun_out,
   output logic                       clip_out
);

   localparam int ACC_W = DATA_W + $clog2(NUM_CH + 1);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
      if (a > SAT_MAX) begin
         return SAT_MAX[DATA_W-1:0];
      end else if (a < SAT_MIN) begin
         return SAT_MIN[DATA_W-1:0];
      end else begin
         return a[DATA_W-1:0];
      end
   endfunction

   function automatic logic clip_fn(input logic signed [ACC_W-1:0] a);
      return (a > SAT_MAX) || (a < SAT_MIN);
   endfunction

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic signed [ACC_W-1:0]    acc_l_q, acc_l_d;
   logic signed [ACC_W-1:0]    acc_r_q, acc_r_d;
   logic [NUM_CH*DATA_W-1:0]   sh_data_q, sh_data_d;
   logic [2*NUM_CH-1:0]        sh_route_q, sh_route_d;
   logic [NUM_CH*ATT_W-1:0]    sh_att_q, sh_att_d;
   logic signed [DATA_W-1:0]   sample_l_q, sample_l_d;
   logic signed [DATA_W-1:0]   sample_r_q, sample_r_d;
   logic                       valid_q, valid_d;
   logic                       overrun_q, overrun_d;
   logic                       clip_q, clip_d;

   logic signed [DATA_W-1:0]   cur_data;
   logic [ATT_W-1:0]           cur_att;
   logic [1:0]                 cur_route;
   logic signed [DATA_W-1:0]   cur_shift;
   logic signed [ACC_W-1:0]    cur_ext;
   logic                       overrun_set;
   logic                       clip_set;

   // Current voice selected from the shadow copy, attenuated and widened
   always_comb begin
      cur_data  = sh_data_q[int'(idx_q)*DATA_W +: DATA_W];
      cur_att   = sh_att_q[int'(idx_q)*ATT_W +: ATT_W];
      cur_route = sh_route_q[int'(idx_q)*2 +: 2];
      cur_shift = cur_data >>> cur_att;
      cur_ext   = {{(ACC_W-DATA_W){cur_shift[DATA_W-1]}}, cur_shift};
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_l_d     = acc_l_q;
      acc_r_d     = acc_r_q;
      sh_data_d   = sh_data_q;
      sh_route_d  = sh_route_q;
      sh_att_d    = sh_att_q;
      sample_l_d  = sample_l_q;
      sample_r_d  = sample_r_q;
      valid_d     = 1'b0;
      clip_set    = 1'b0;
      overrun_set = sample_valid_in && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (sample_valid_in) begin
               sh_data_d  = note_data_in;
               sh_route_d = stereo_in;
               sh_att_d   = atten_in;
               acc_l_d    = '0;
               acc_r_d    = '0;
               idx_d      = '0;
               state_d    = ACCUM;
            end
         end
         ACCUM: begin
            if (cur_route[1]) begin
               acc_l_d = acc_l_q + cur_ext;
            end
            if (cur_route[0]) begin
               acc_r_d = acc_r_q + cur_ext;
            end
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            sample_l_d = sat_fn(acc_l_q);
            sample_r_d = sat_fn(acc_r_q);
            valid_d    = 1'b1;
            clip_set   = clip_fn(acc_l_q) || clip_fn(acc_r_q);
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A flag being set in the same cycle as a clear must survive
      overrun_d = overrun_set ? 1'b1 : (clear_flags_in ? 1'b0 : overrun_q);
      clip_d    = clip_set    ? 1'b1 : (clear_flags_in ? 1'b0 : clip_q);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         acc_l_q    <= '0;
         acc_r_q    <= '0;
         sh_data_q  <= '0;
         sh_route_q <= '0;
         sh_att_q   <= '0;
         sample_l_q <= '0;
         sample_r_q <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         clip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_l_q    <= acc_l_d;
         acc_r_q    <= acc_r_d;
         sh_data_q  <= sh_data_d;
         sh_route_q <= sh_route_d;
         sh_att_q   <= sh_att_d;
         sample_l_q <= sample_l_d;
         sample_r_q <= sample_r_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         clip_q     <= clip_d;
      end
   end

   assign sample_l_out     = sample_l_q;
   assign sample_r_out     = sample_r_q;
   assign sample_valid_out = valid_q;
   assign busy_out         = (state_q != IDLE);
   assign overrun_out      = overrun_q;
   assign clip_out         = clip_q;

endmodule

// File: tb/tb_stereo_mixer_seq.sv
// Directed bench for stereo_mixer_seq (3 channels, 16-bit): reset, routing, saturation,
// attenuation, overrun and back-to-back strobes against hand-computed results.
module tb_stereo_mixer_seq;

   localparam int NUM_CH = 3;
   localparam int DATA_W = 16;
   localparam int ATT_W  = 3;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      strobe;
   logic [NUM_CH*DATA_W-1:0]  note;
   logic [2*NUM_CH-1:0]       route;
   logic [NUM_CH*ATT_W-1:0]   att;
   logic                      clr;
   logic signed [DATA_W-1:0]  l_out;
   logic signed [DATA_W-1:0]  r_out;
   logic                      vld;
   logic                      busy;
   logic                      ovr;
   logic                      clip;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   stereo_mixer_seq #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .ATT_W  (ATT_W)
   ) dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .sample_valid_in  (strobe),
      .note_data_in     (note),
      .stereo_in        (route),
      .atten_in         (att),
      .clear_flags_in   (clr),
      .sample_l_out     (l_out),
      .sample_r_out     (r_out),
      .sample_valid_out (vld),
      .busy_out         (busy),
      .overrun_out      (ovr),
      .clip_out         (clip)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int d0, input int d1, input int d2,
                       input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2,
                       input int a0, input int a1, input int a2);
      note  = {16'(d2), 16'(d1), 16'(d0)};
      route = {r2, r1, r0};
      att   = {3'(a2), 3'(a1), 3'(a0)};
   endtask

   // Strobe in cycle 0, return positioned in cycle NUM_CH+2
   task automatic run_mix();
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      repeat (NUM_CH + 1) tick();
   endtask

   task automatic test_reset();
      int pulses;
      rst = 1'b1; strobe = 1'b0; clr = 1'b0;
      load(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      repeat (2) tick();
      checks++; if (l_out !== 16'sd0) begin errors++; $display("FAIL reset_l: got %0d expected 0", l_out); end
      checks++; if (r_out !== 16'sd0) begin errors++; $display("FAIL reset_r: got %0d expected 0", r_out); end
      checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (ovr !== 1'b0 || clip !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovr=%b clip=%b expected 0 0", ovr, clip); end
      #2 rst = 1'b0;
      tick();
      load(10, 20, 30, 2'b11, 2'b11, 2'b11, 0, 0, 0);
      run_mix();
      checks++; if (vld !== 1'b1 || l_out !== 16'sd60 || r_out !== 16'sd60) begin
         errors++; $display("FAIL reset_premix: got vld=%b l=%0d r=%0d expected 1 60 60", vld, l_out, r_out); end
      // second strobe accepted in the valid cycle, then killed by reset mid-accumulation
      load(1000, 1000, 1000, 2'b11, 2'b11, 2'b11, 0, 0, 0);
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_midbusy: got %b expected 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (l_out !== 16'sd0 || r_out !== 16'sd0 || busy !== 1'b0 || vld !== 1'b0) begin
         errors++; $display("FAIL reset_async: got l=%0d r=%0d busy=%b vld=%b expected 0 0 0 0", l_out, r_out, busy, vld); end
      #3 rst = 1'b0;
      pulses = 0;
      repeat (8) begin
         tick();
         if (vld === 1'b1) pulses++;
      end
      checks++; if (pulses != 0 || l_out !== 16'sd0) begin
         errors++; $display("FAIL reset_nopulse: got pulses=%0d l=%0d expected 0 0", pulses, l_out); end
   endtask

   task automatic test_routing();
      load(100, 200, 300, 2'b10, 2'b01, 2'b11, 0, 0, 0);
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      load(-5, -5, -5, 2'b11, 2'b11, 2'b11, 7, 7, 7);
      for (int c = 1; c <= NUM_CH + 1; c++) begin
         checks++; if (busy !== 1'b1 || vld !== 1'b0) begin
            errors++; $display("FAIL route_busy_c%0d: got busy=%b vld=%b expected 1 0", c, busy, vld); end
         tick();
      end
      checks++; if (vld !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL route_valid: got vld=%b busy=%b expected 1 0", vld, busy); end
      checks++; if (l_out !== 16'sd400) begin errors++; $display("FAIL route_l: got %0d expected 400", l_out); end
      checks++; if (r_out !== 16'sd500) begin errors++; $display("FAIL route_r: got %0d expected 500", r_out); end
      tick();
      checks++; if (vld !== 1'b0 || l_out !== 16'sd400 || r_out !== 16'sd500) begin
         errors++; $display("FAIL route_hold: got vld=%b l=%0d r=%0d expected 0 400 500", vld, l_out, r_out); end
   endtask

   task automatic test_saturation();
      checks++; if (clip !== 1'b0) begin errors++; $display("FAIL sat_clip_pre: got %b expected 0", clip); end
      load(10000, 10000, 12767, 2'b11, 2'b11, 2'b11, 0, 0, 0);
      run_mix();
      checks++; if (l_out !== 16'sd32767 || r_out !== 16'sd32767 || clip !== 1'b0) begin
         errors++; $display("FAIL sat_edge: got l=%0d r=%0d clip=%b expected 32767 32767 0", l_out, r_out, clip); end
      load(20000, 20000, 20000, 2'b11, 2'b11, 2'b11, 0, 0, 0);
      run_mix();
      checks++; if (l_out !== 16'sd32767 || r_out !== 16'sd32767) begin
         errors++; $display("FAIL sat_pos: got l=%0d r=%0d expected 32767 32767", l_out, r_out); end
      checks++; if (clip !== 1'b1) begin errors++; $display("FAIL sat_clip: got %b expected 1", clip); end
      load(-20000, -20000, -20000, 2'b11, 2'b11, 2'b11, 0, 0, 0);
      run_mix();
      checks++; if (l_out !== -16'sd32768 || r_out !== -16'sd32768) begin
         errors++; $display("FAIL sat_neg: got l=%0d r=%0d expected -32768 -32768", l_out, r_out); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (clip !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b expected 0", clip); end
   endtask

   task automatic test_atten();
      load(-1000, -1, 5000, 2'b10, 2'b01, 2'b00, 2, 3, 0);
      run_mix();
      checks++; if (l_out !== -16'sd250) begin errors++; $display("FAIL att_m1000: got %0d expected -250", l_out); end
      checks++; if (r_out !== -16'sd1) begin errors++; $display("FAIL att_m1: got %0d expected -1", r_out); end
      load(-7, 1000, 5000, 2'b11, 2'b01, 2'b00, 1, 3, 7);
      run_mix();
      checks++; if (l_out !== -16'sd4 || r_out !== 16'sd121) begin
         errors++; $display("FAIL att_odd: got l=%0d r=%0d expected -4 121", l_out, r_out); end
      load(-32768, 32767, 0, 2'b10, 2'b01, 2'b00, 7, 7, 0);
      run_mix();
      checks++; if (l_out !== -16'sd256 || r_out !== 16'sd255) begin
         errors++; $display("FAIL att_max: got l=%0d r=%0d expected -256 255", l_out, r_out); end
   endtask

   task automatic test_overrun();
      int pulses;
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b expected 0", ovr); end
      load(1, 2, 3, 2'b11, 2'b11, 2'b11, 0, 0, 0);
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick();
      load(100, 100, 100, 2'b11, 2'b11, 2'b11, 0, 0, 0);
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", ovr); end
      pulses = 0;
      for (int c = 3; c <= 9; c++) begin
         if (c == 5) begin
            checks++; if (vld !== 1'b1 || l_out !== 16'sd6 || r_out !== 16'sd6) begin
               errors++; $display("FAIL ovr_result: got vld=%b l=%0d r=%0d expected 1 6 6", vld, l_out, r_out); end
         end
         if (vld === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", pulses); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
      // strobe-while-busy coinciding with a clear keeps the flag set
      strobe = 1'b1;
      tick();
      clr = 1'b1;
      tick();
      strobe = 1'b0;
      clr = 1'b0;
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", ovr); end
      repeat (3) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear2: got %b expected 0", ovr); end
   endtask

   task automatic test_back_to_back();
      logic              exp_vld;
      logic signed [15:0] exp_l, exp_r;
      int                 pulses;
      pulses = 0;
      for (int c = 0; c <= 16; c++) begin
         exp_vld = (c == 5) || (c == 10) || (c == 15);
         if (c == 5)  begin exp_l = -16'sd500; exp_r = -16'sd1000; end
         if (c == 10) begin exp_l = 16'sd0;    exp_r = 16'sd24;    end
         if (c == 15) begin exp_l = 16'sd0;    exp_r = 16'sd0;     end
         if (vld === 1'b1) pulses++;
         if (exp_vld) begin
            checks++; if (vld !== 1'b1 || l_out !== exp_l || r_out !== exp_r) begin
               errors++; $display("FAIL b2b_c%0d: got vld=%b l=%0d r=%0d expected 1 %0d %0d", c, vld, l_out, r_out, exp_l, exp_r); end
         end
         strobe = 1'b0;
         if (c == 0)  begin load(1000, -2000, 500, 2'b11, 2'b11, 2'b10, 0, 0, 0); strobe = 1'b1; end
         if (c == 5)  begin load(7, 8, 9, 2'b01, 2'b01, 2'b01, 0, 0, 0);          strobe = 1'b1; end
         if (c == 10) begin load(5000, 5000, 5000, 2'b00, 2'b00, 2'b00, 0, 0, 0); strobe = 1'b1; end
         tick();
      end
      strobe = 1'b0;
      checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", ovr); end
   endtask

   initial begin
      test_reset();
      test_routing();
      test_saturation();
      test_atten();
      test_overrun();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
